rotate_left_pipe: RTL and testbench

- Pipelined left rotator: the counterpart of the combinational right rotator in the multifunction shifter.
- Structured as a log-depth barrel. Stage k rotates left by 2^k when bit k of the amount is set.
- Accepts one operand per cycle on a valid/ready input. Results leave in order on a valid/ready output.
- Sits between the operand register file and the shifter result mux. Replaces the wide single-cycle left rotate on timing-critical paths.

---
 rtl/shifter_pkg.sv | 21 ++
 rtl/rotate_left_stage.sv | 54 +++++
 rtl/rotate_left_pipe.sv | 72 +++++++
 tb/tb_rotate_left_pipe.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/shifter_pkg.sv
// Shared shifter constants: clog2 helper plus the default datapath and
// rotate-amount widths used by the rotators and the shifter top.
package shifter_pkg;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'sd1 <<< i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

    localparam int WIDTH_16 = 16;
    localparam int WIDTH_32 = 32;
    localparam int AMT_W_16 = clog2(WIDTH_16);
    localparam int AMT_W_32 = clog2(WIDTH_32);

endpackage

// File: rtl/rotate_left_stage.sv
// One barrel stage: conditionally rotates left by SHIFT when its amount bit
// is set, and registers the result with its valid bit and carried amount.
module rotate_left_stage
    import shifter_pkg::*;
#(
    parameter int WIDTH = WIDTH_32,
    parameter int AMT_W = AMT_W_32,
    parameter int SHIFT = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             up_valid,
    input  logic [WIDTH-1:0] up_data,
    input  logic [AMT_W-1:0] up_amt,
    input  logic             down_adv,
    output logic             adv,
    output logic             valid,
    output logic [WIDTH-1:0] data,
    output logic [AMT_W-1:0] amt
);

    localparam int BIT = clog2(SHIFT);

    logic [WIDTH-1:0] rot_s;

    // Fixed-distance rotate selected by this stage's amount bit.
    always_comb begin
        rot_s = up_data;
        if (up_amt[BIT]) begin
            rot_s = {up_data[WIDTH-1-SHIFT:0], up_data[WIDTH-1:WIDTH-SHIFT]};
        end else begin
            rot_s = up_data;
        end
    end

    // An empty stage always accepts, so bubbles collapse under a stall.
    assign adv = !valid || down_adv;

    // Stage register; payload only updates on a real operand.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid <= 1'b0;
            data  <= {WIDTH{1'b0}};
            amt   <= {AMT_W{1'b0}};
        end else if (adv) begin
            valid <= up_valid;
            if (up_valid) begin
                data <= rot_s;
                amt  <= up_amt;
            end
        end
    end

endmodule

// File: rtl/rotate_left_pipe.sv
// Pipelined left rotator: AMT_W barrel stages, stage k rotating by 2^k,
// with a valid/ready handshake on both ends and registered outputs.
module rotate_left_pipe
    import shifter_pkg::*;
#(
    parameter int WIDTH = WIDTH_32,
    parameter int AMT_W = clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [AMT_W-1:0] in_amt,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    genvar k;
    for (k = 0; k < AMT_W; k++) begin : g_stage
        logic             up_valid_s;
        logic [WIDTH-1:0] up_data_s;
        logic [AMT_W-1:0] up_amt_s;
        logic             down_adv_s;
        logic             adv_s;
        logic             valid_s;
        logic [WIDTH-1:0] data_s;
        logic [AMT_W-1:0] amt_s;

        if (k == 0) begin : g_first
            assign up_valid_s = in_valid;
            assign up_data_s  = in_data;
            assign up_amt_s   = in_amt;
        end else begin : g_chain
            assign up_valid_s = g_stage[k-1].valid_s;
            assign up_data_s  = g_stage[k-1].data_s;
            assign up_amt_s   = g_stage[k-1].amt_s;
        end

        // The ready chain runs backwards from the consumer through each stage.
        if (k == AMT_W - 1) begin : g_last
            logic unused_amt_s;
            assign down_adv_s   = out_ready;
            assign unused_amt_s = ^amt_s;
        end else begin : g_next
            assign down_adv_s = g_stage[k+1].adv_s;
        end

        rotate_left_stage #(
            .WIDTH (WIDTH),
            .AMT_W (AMT_W),
            .SHIFT (1 << k)
        ) u_stage (
            .clk      (clk),
            .reset    (reset),
            .up_valid (up_valid_s),
            .up_data  (up_data_s),
            .up_amt   (up_amt_s),
            .down_adv (down_adv_s),
            .adv      (adv_s),
            .valid    (valid_s),
            .data     (data_s),
            .amt      (amt_s)
        );
    end

    assign in_ready  = g_stage[0].adv_s;
    assign out_valid = g_stage[AMT_W-1].valid_s;
    assign out_data  = g_stage[AMT_W-1].data_s;

endmodule

// File: tb/tb_rotate_left_pipe.sv
// Self-checking bench for rotate_left_pipe at WIDTH=16 and WIDTH=32 using a
// queue-based rotate model plus directed literal expectations.
module tb_rotate_left_pipe;

    logic        clk;
    logic        reset;

    logic        in_valid16, in_ready16, out_valid16, out_ready16;
    logic [15:0] in_data16, out_data16;
    logic [3:0]  in_amt16;

    logic        in_valid32, in_ready32, out_valid32, out_ready32;
    logic [31:0] in_data32, out_data32;
    logic [4:0]  in_amt32;

    int checks;
    int errors;
    int cyc;

    logic [63:0] q16[$];
    logic [63:0] q32[$];
    int          xfer16[$];
    logic        stall16, stall32;
    logic [15:0] prev16;
    logic [31:0] prev32;

    rotate_left_pipe #(.WIDTH(16), .AMT_W(4)) dut16 (
        .clk(clk), .reset(reset),
        .in_valid(in_valid16), .in_ready(in_ready16), .in_data(in_data16), .in_amt(in_amt16),
        .out_valid(out_valid16), .out_ready(out_ready16), .out_data(out_data16)
    );

    rotate_left_pipe #(.WIDTH(32), .AMT_W(5)) dut32 (
        .clk(clk), .reset(reset),
        .in_valid(in_valid32), .in_ready(in_ready32), .in_data(in_data32), .in_amt(in_amt32),
        .out_valid(out_valid32), .out_ready(out_ready32), .out_data(out_data32)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference rotate by plain arithmetic on a wide word.
    function automatic logic [63:0] rotl(input logic [63:0] a, input int amt, input int w);
        logic [63:0] mask;
        mask = (64'd1 << w) - 64'd1;
        a = a & mask;
        return ((a << amt) | (a >> (w - amt))) & mask;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard and output checker for both instances, sampled mid-cycle.
    always @(negedge clk) begin
        cyc++;
        if (reset) begin
            q16.delete();
            q32.delete();
            stall16 = 1'b0;
            stall32 = 1'b0;
            chk("rst_out_valid16", {63'd0, out_valid16}, 64'd0);
            chk("rst_out_data16", {48'd0, out_data16}, 64'd0);
            chk("rst_out_valid32", {63'd0, out_valid32}, 64'd0);
            chk("rst_out_data32", {32'd0, out_data32}, 64'd0);
        end else begin
            if (out_valid16) begin
                if (q16.size() == 0) begin
                    chk("out16_spurious", 64'd1, 64'd0);
                end else begin
                    chk("out16_data", {48'd0, out_data16}, q16[0]);
                end
                if (stall16) chk("out16_hold", {48'd0, out_data16}, {48'd0, prev16});
                if (out_ready16) begin
                    if (q16.size() != 0) void'(q16.pop_front());
                    xfer16.push_back(cyc);
                end
            end else if (stall16) begin
                chk("out16_valid_dropped", 64'd0, 64'd1);
            end
            stall16 = out_valid16 && !out_ready16;
            prev16  = out_data16;
            if (in_valid16 && in_ready16) q16.push_back(rotl({48'd0, in_data16}, int'(in_amt16), 16));

            if (out_valid32) begin
                if (q32.size() == 0) begin
                    chk("out32_spurious", 64'd1, 64'd0);
                end else begin
                    chk("out32_data", {32'd0, out_data32}, q32[0]);
                end
                if (stall32) chk("out32_hold", {32'd0, out_data32}, {32'd0, prev32});
                if (out_ready32 && q32.size() != 0) void'(q32.pop_front());
            end else if (stall32) begin
                chk("out32_valid_dropped", 64'd0, 64'd1);
            end
            stall32 = out_valid32 && !out_ready32;
            prev32  = out_data32;
            if (in_valid32 && in_ready32) q32.push_back(rotl({32'd0, in_data32}, int'(in_amt32), 32));
        end
    end

    task automatic send16(input logic [15:0] d, input logic [3:0] a, output logic first);
        int n;
        logic acc;
        in_valid16 = 1'b1; in_data16 = d; in_amt16 = a;
        n = 0; first = 1'b0; acc = 1'b0;
        do begin
            @(negedge clk);
            acc = in_ready16;
            if (n == 0) first = acc;
            @(posedge clk); #1;
            n++;
        end while (!acc && n < 500);
        if (!acc) chk("send16_timeout", 64'd0, 64'd1);
        in_valid16 = 1'b0;
    endtask

    task automatic send32(input logic [31:0] d, input logic [4:0] a, output logic first);
        int n;
        logic acc;
        in_valid32 = 1'b1; in_data32 = d; in_amt32 = a;
        n = 0; first = 1'b0; acc = 1'b0;
        do begin
            @(negedge clk);
            acc = in_ready32;
            if (n == 0) first = acc;
            @(posedge clk); #1;
            n++;
        end while (!acc && n < 500);
        if (!acc) chk("send32_timeout", 64'd0, 64'd1);
        in_valid32 = 1'b0;
    endtask

    // One operand through an idle pipe: checks latency and a literal result.
    task automatic single16(input logic [15:0] d, input logic [3:0] a, input logic [15:0] exp);
        logic f;
        int n;
        send16(d, a, f);
        n = 1;
        @(negedge clk);
        while (!out_valid16 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("lat16", 64'(n), 64'd4);
        chk("lit16", {48'd0, out_data16}, {48'd0, exp});
        @(posedge clk); #1;
    endtask

    task automatic single32(input logic [31:0] d, input logic [4:0] a, input logic [31:0] exp);
        logic f;
        int n;
        send32(d, a, f);
        n = 1;
        @(negedge clk);
        while (!out_valid32 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("lat32", 64'(n), 64'd5);
        chk("lit32", {32'd0, out_data32}, {32'd0, exp});
        @(posedge clk); #1;
    endtask

    task automatic drain16();
        int n;
        n = 0;
        while (q16.size() != 0 && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        chk("drain16", 64'(q16.size()), 64'd0);
    endtask

    task automatic drain32();
        int n;
        n = 0;
        while (q32.size() != 0 && n < 3000) begin
            @(posedge clk); #1;
            n++;
        end
        chk("drain32", 64'(q32.size()), 64'd0);
    endtask

    initial begin
        logic        f;
        logic        done;
        logic [15:0] one;
        logic [15:0] oh;
        checks = 0; errors = 0; cyc = 0;
        stall16 = 1'b0; stall32 = 1'b0; prev16 = 16'd0; prev32 = 32'd0;
        reset = 1'b1;
        in_valid16 = 1'b0; in_data16 = 16'd0; in_amt16 = 4'd0; out_ready16 = 1'b1;
        in_valid32 = 1'b0; in_data32 = 32'd0; in_amt32 = 5'd0; out_ready32 = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        chk("init_in_ready16", {63'd0, in_ready16}, 64'd1);
        chk("init_in_ready32", {63'd0, in_ready32}, 64'd1);
        chk("init_out_valid16", {63'd0, out_valid16}, 64'd0);

        single16(16'h8001, 4'd1, 16'h0003);
        single16(16'h1234, 4'd4, 16'h2341);
        single16(16'h0001, 4'd15, 16'h8000);
        single16(16'hA5C3, 4'd0, 16'hA5C3);
        single32(32'h8000_0001, 5'd1, 32'h0000_0003);

        one = 16'h0001;
        for (int a = 0; a < 16; a++) begin
            oh = one << a;
            single16(16'h0001, 4'(a), oh);
            single16(16'hFFFE, 4'(a), ~oh);
        end

        // Streaming: back-to-back operands, results on consecutive cycles.
        xfer16.delete();
        for (int i = 0; i < 8; i++) begin
            send16(16'h1357 + 16'(i * 16'h0111), 4'(i * 3), f);
            chk("stream_in_ready", {63'd0, f}, 64'd1);
        end
        drain16();
        chk("stream_count", 64'(xfer16.size()), 64'd8);
        if (xfer16.size() == 8) chk("stream_span", 64'(xfer16[7] - xfer16[0]), 64'd7);

        // Backpressure: fill, stall, then release with a simultaneous accept.
        out_ready16 = 1'b0;
        send16(16'h0011, 4'd1, f); chk("bp_acc0", {63'd0, f}, 64'd1);
        send16(16'h00F0, 4'd4, f); chk("bp_acc1", {63'd0, f}, 64'd1);
        send16(16'hC001, 4'd2, f); chk("bp_acc2", {63'd0, f}, 64'd1);
        send16(16'h0F0F, 4'd8, f); chk("bp_acc3", {63'd0, f}, 64'd1);
        @(negedge clk);
        chk("bp_full_in_ready", {63'd0, in_ready16}, 64'd0);
        chk("bp_head", {48'd0, out_data16}, 64'h0022);
        fork
            send16(16'h4321, 4'd12, f);
            begin
                repeat (5) @(posedge clk);
                #1;
                chk("bp_hold_lit", {48'd0, out_data16}, 64'h0022);
                out_ready16 = 1'b1;
            end
        join
        send16(16'h0003, 4'd14, f);
        send16(16'hBEEF, 4'd7, f);
        drain16();

        // Reset with three operands in flight.
        send16(16'h1111, 4'd1, f);
        send16(16'h2222, 4'd2, f);
        send16(16'h3333, 4'd3, f);
        reset = 1'b1;
        #1;
        chk("rst_now_valid", {63'd0, out_valid16}, 64'd0);
        chk("rst_now_data", {48'd0, out_data16}, 64'd0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        chk("rst_in_ready", {63'd0, in_ready16}, 64'd1);
        single16(16'h00F0, 4'd8, 16'hF000);

        // WIDTH=32 random backpressure stream.
        done = 1'b0;
        fork
            begin
                for (int i = 0; i < 1000; i++) begin
                    send32($urandom, 5'($urandom_range(0, 31)), f);
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk); #1;
                    out_ready32 = 1'($urandom_range(0, 1));
                end
            end
        join
        out_ready32 = 1'b1;
        drain32();

        repeat (3) @(posedge clk);
        #1;
        chk("final_q16", 64'(q16.size()), 64'd0);
        chk("final_q32", 64'(q32.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
